hog_cell_histogram: RTL
=======================

# hog_cell_histogram

Per-cell orientation histogram accumulator for the HOG pipeline. It consumes the per-pixel gradient stream (orientation bin plus magnitude) together with the 7-bit cell index produced by the cell counter. It sums the magnitudes of each cell's pixels into 9 orientation bins, then hands the finished histogram to block normalisation over a valid/ready handshake. One accumulator bank and one output register form a two-deep buffer, so accumulation of cell k+1 overlaps the drain of cell k.

## Interface
Parameters:
- BIN_NUM, 9, number of orientation bins
- MAG_W, 8, gradient magnitude width
- PIX_PER_CELL, 64, pixels per cell (8x8)
- ACC_W, 14, per-bin accumulator width; must satisfy 2^ACC_W > PIX_PER_CELL*(2^MAG_W-1)
- IDX_W, 7, cell index width

Ports:
- iClk  in  1  clock
- iRst_n  in  1  reset, synchronous, active-low
- iValid  in  1  input pixel valid
- oReady  out  1  block accepts a pixel this cycle
- iBin  in  4  orientation bin, legal range 0..BIN_NUM-1
- iMag  in  MAG_W  gradient magnitude
- iCellIdx  in  IDX_W  cell index from the cell counter, sampled on the first pixel of a cell
- oValid  out  1  histogram valid
- iReady  in  1  downstream accepts the histogram
- oHist  out  BIN_NUM*ACC_W  bin b occupies bits [b*ACC_W +: ACC_W]
- oCellIdx  out  IDX_W  index of the cell held in oHist
- oErr  out  1  sticky flag, set when an illegal bin is seen

## Operation
- Pixel accept: iValid && oReady. Histogram accept: oValid && iReady.
- On each pixel accept:
  - acc[iBin] += iMag; no saturation is needed because widths are guaranteed.
  - Pixel counter pcnt increments.
  - If pcnt==0, iCellIdx is captured into idx_acc.
- iBin >= BIN_NUM: the magnitude is discarded, the pixel still counts toward the cell, and oErr is set until reset.
- Last pixel (pcnt==PIX_PER_CELL-1) accepted in cycle N:
  - The final sum, including this pixel, is the cell result.
  - Output slot free, or draining in cycle N: the result is written to oHist/oCellIdx, oValid=1 from N+1, and acc and pcnt clear.
  - Output slot occupied and not draining: FSM enters FULL. Acc keeps the completed sum and oReady=0.
- FSM states:
  - ACC: oReady=1. Goes to FULL on the last-pixel accept if the slot is blocked.
  - FULL: oReady=0. On a histogram accept, the acc is transferred to the output in the same cycle (oValid stays 1, new data from the next cycle), acc and pcnt clear, and the FSM returns to ACC.
- Histogram accept with nothing to transfer: oValid=0 next cycle.
- oHist and oCellIdx are held stable while oValid=1 && !iReady.

## Timing
- Reset values: oValid=0, oHist=0, oCellIdx=0, oErr=0, oReady=1 once reset is released; acc=0, pcnt=0, FSM=ACC. While iRst_n=0, oReady=0.
- Latency: 1 cycle from the last pixel accept to oValid, when the slot is free.
- Throughput: 1 pixel/cycle sustained while downstream drains at least one histogram per PIX_PER_CELL cycles.
- Back-to-back cells: the first pixel of cell k+1 may be accepted the cycle after the last pixel of cell k. It goes into the cleared acc and the same-cycle clear must not lose it.
- Reset mid-cell or in FULL: the partial sum is discarded, any pending oValid drops next cycle, and oErr clears.
- iCellIdx wrap 127→0 is passed through unchanged.

## Structure
- Shared package hog_pkg holds BIN_NUM, MAG_W, ACC_W, PIX_PER_CELL, IDX_W, the ACC/FULL state typedef, and the bin-slice helper.
- One sub-module, hog_bin_acc: a BIN_NUM-wide accumulator bank with add-at-index and clear ports.
- The top level contains the pixel counter, FSM and output register.

## Test plan
- Single cell, all pixels iBin=3, iMag=10, iReady=1 → one oValid pulse with bin3=640, other bins 0, oCellIdx = iCellIdx sampled on the first pixel, 1 cycle after the last pixel.
- Max magnitude: 64 pixels iBin=8, iMag=255 → bin8=16320 with no wrap.
- Backpressure: iReady=0 across two full cells → cell 1 is held stable, oReady=0 after cell 2 completes; iReady=1 for one cycle → cell 2 appears next cycle and oReady returns to 1.
- Continuous stream of 4 cells, one pixel per cycle, iReady=1 → 4 histograms spaced 64 cycles apart with no dropped pixels.
- Pixel with iBin=12 and iMag=50 inside a cell → oErr=1 and persists, bin sums exclude 50, and the cell still completes after 64 pixels.
- Reset asserted after 30 pixels and released → the next 64 pixels form a fresh cell with no residue from the first 30.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared constants, FSM state type and bin-slice helper for the HOG cell histogram.
package hog_pkg;
  localparam int BIN_NUM      = 9;
  localparam int MAG_W        = 8;
  localparam int PIX_PER_CELL = 64;
  localparam int ACC_W        = 14;
  localparam int IDX_W        = 7;
  localparam int BIN_W        = 4;

  // ACC: collecting pixels; FULL: finished cell parked in acc, waiting for the output slot
  typedef enum logic {ST_ACC = 1'b0, ST_FULL = 1'b1} cellState_t;

  // Extract bin b from a packed histogram (bin b at [b*ACC_W +: ACC_W])
  function automatic logic [ACC_W-1:0] binSlice(input logic [BIN_NUM*ACC_W-1:0] hist, input int b);
    return hist[b*ACC_W +: ACC_W];
  endfunction
endpackage

// File: rtl/hog_bin_acc.sv
// Bank of per-bin magnitude accumulators with add-at-index and clear.
// oSum is the bank contents with this cycle's add already applied, so the
// owner can capture a finished cell including its last pixel.
module hog_bin_acc #(
  parameter int BIN_NUM = hog_pkg::BIN_NUM,
  parameter int MAG_W   = hog_pkg::MAG_W,
  parameter int ACC_W   = hog_pkg::ACC_W,
  parameter int BIN_W   = hog_pkg::BIN_W
) (
  input  logic                            iClk,
  input  logic                            iRst_n,
  input  logic                            iClr,
  input  logic                            iAdd,
  input  logic [BIN_W-1:0]                iBin,
  input  logic [MAG_W-1:0]                iMag,
  output logic [BIN_NUM-1:0][ACC_W-1:0]   oSum
);
  genvar b;
  generate
    for (b = 0; b < BIN_NUM; b++) begin : g_bin
      logic [ACC_W-1:0] acc;
      logic             hit;

      assign hit     = iAdd && (iBin == BIN_W'(b));
      assign oSum[b] = hit ? acc + ACC_W'(iMag) : acc;

      // Clear wins over add: a clear only coincides with an add when the
      // sum is being captured into the output register this same cycle.
      always_ff @(posedge iClk) begin
        if (!iRst_n || iClr) acc <= '0;
        else if (hit)        acc <= oSum[b];
      end
    end
  endgenerate
endmodule

// File: rtl/hog_cell_histogram.sv
// Per-cell orientation histogram: accumulates gradient magnitudes into bins
// over PIX_PER_CELL pixels, then presents the cell over valid/ready. The acc
// bank plus the output register give two-deep buffering between cells.
module hog_cell_histogram #(
  parameter int BIN_NUM      = hog_pkg::BIN_NUM,
  parameter int MAG_W        = hog_pkg::MAG_W,
  parameter int PIX_PER_CELL = hog_pkg::PIX_PER_CELL,
  parameter int ACC_W        = hog_pkg::ACC_W,
  parameter int IDX_W        = hog_pkg::IDX_W
) (
  input  logic                       iClk,
  input  logic                       iRst_n,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic [3:0]                 iBin,
  input  logic [MAG_W-1:0]           iMag,
  input  logic [IDX_W-1:0]           iCellIdx,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [BIN_NUM*ACC_W-1:0]   oHist,
  output logic [IDX_W-1:0]           oCellIdx,
  output logic                       oErr
);
  import hog_pkg::*;

  localparam int PCNT_W = (PIX_PER_CELL > 1) ? $clog2(PIX_PER_CELL) : 1;

  cellState_t                    state, stateNext;
  logic [PCNT_W-1:0]             pcnt;
  logic [IDX_W-1:0]              idxAcc, idxCur;
  logic [BIN_NUM-1:0][ACC_W-1:0] sum;
  logic                          pixAcc, histAcc, lastPix, binOk, load;

  assign oReady  = iRst_n && (state == ST_ACC);
  assign pixAcc  = iValid && oReady;
  assign histAcc = oValid && iReady;
  assign lastPix = pixAcc && (pcnt == PCNT_W'(PIX_PER_CELL - 1));
  assign binOk   = iBin < 4'(BIN_NUM);
  // On a single-pixel-in-acc capture the index is still on the input port
  assign idxCur  = (state == ST_ACC && pcnt == '0) ? iCellIdx : idxAcc;

  hog_bin_acc #(
    .BIN_NUM (BIN_NUM),
    .MAG_W   (MAG_W),
    .ACC_W   (ACC_W),
    .BIN_W   (4)
  ) uBinAcc (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClr   (load),
    .iAdd   (pixAcc && binOk),
    .iBin   (iBin),
    .iMag   (iMag),
    .oSum   (sum)
  );

  // State register
  always_ff @(posedge iClk) begin
    if (!iRst_n) state <= ST_ACC;
    else         state <= stateNext;
  end

  // Next state and output-load decision: load when a finished cell can move into a free or draining slot
  always_comb begin
    stateNext = state;
    load      = 1'b0;
    case (state)
      ST_ACC: begin
        if (lastPix) begin
          if (!oValid || histAcc) load      = 1'b1;
          else                    stateNext = ST_FULL;
        end
      end
      ST_FULL: begin
        if (histAcc) begin
          load      = 1'b1;
          stateNext = ST_ACC;
        end
      end
      default: stateNext = ST_ACC;
    endcase
  end

  // Pixel counter and cell index capture; counter parks at the last pixel while FULL
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pcnt   <= '0;
      idxAcc <= '0;
    end else begin
      if (pixAcc && pcnt == '0) idxAcc <= iCellIdx;
      if (load)                 pcnt   <= '0;
      else if (pixAcc && !lastPix) pcnt <= pcnt + 1'b1;
    end
  end

  // Output register: held while oValid && !iReady
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oValid   <= 1'b0;
      oHist    <= '0;
      oCellIdx <= '0;
    end else if (load) begin
      oValid   <= 1'b1;
      oHist    <= sum;
      oCellIdx <= idxCur;
    end else if (histAcc) begin
      oValid   <= 1'b0;
    end
  end

  // Sticky illegal-bin flag
  always_ff @(posedge iClk) begin
    if (!iRst_n)              oErr <= 1'b0;
    else if (pixAcc && !binOk) oErr <= 1'b1;
  end
endmodule
